ptosda_tx: RTL and testbench

Parallel-to-serial transmitter that drives the two-wire scl/sda link consumed by the 16-line high-output decoder stage.
- Accepts a DATA_W-bit nibble over a valid/ready handshake.
- Emits a start condition, the data bits MSB first, then a stop condition.
- Fully synchronous to the system clock. scl is a divided, registered output, never a gated clock.

---
 rtl/ptosda_pkg.sv | 23 ++
 rtl/ptosda_if.sv | 24 ++
 rtl/ptosda_sda_phase_tick.sv | 34 +++
 rtl/ptosda_tx.sv | 136 +++++++++++++
 tb/tb_ptosda_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ptosda_pkg.sv
// Shared types and constants for the ptosda serial transmitter.
package ptosda_pkg;

    localparam int DATA_W_DEF   = 4;
    localparam int CLK_DIV_DEF  = 2;
    localparam int FRAME_PHASES = 2 * DATA_W_DEF + 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT_LO,
        BIT_HI,
        STOP_LO,
        STOP_SU,
        STOP
    } state_t;

    // Number of scl phases in one frame for a given data width.
    function automatic int frame_phases(input int dw);
        return 2 * dw + 4;
    endfunction

endpackage

// File: rtl/ptosda_if.sv
// Handshake and serial-link bundle between a data source and ptosda_tx.
interface ptosda_if
    import ptosda_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              scl;
    logic              sda;

    modport master (
        output in_data, in_valid,
        input  in_ready, busy, done, scl, sda
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, busy, done, scl, sda
    );
endinterface

// File: rtl/ptosda_sda_phase_tick.sv
// Phase timer: counts 0..CLK_DIV-1 and flags the last and second-to-last cycle.
module sda_phase_tick
    import ptosda_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_phase_end,
    output logic o_pre_end
);
    localparam logic [7:0] LAST    = 8'(CLK_DIV - 1);
    localparam logic [7:0] PRE     = (CLK_DIV >= 2) ? 8'(CLK_DIV - 2) : 8'd0;
    localparam bit         HAS_PRE = (CLK_DIV >= 2);

    logic [7:0] r_cnt;

    // Free-running phase counter, held at zero while loaded so a new frame starts on a clean phase.
    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == LAST) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_phase_end = !i_load && (r_cnt == LAST);
    // Lets the FSM register a pulse that lands exactly on the last cycle of a phase.
    assign o_pre_end   = HAS_PRE && !i_load && (r_cnt == PRE);

endmodule

// File: rtl/ptosda_tx.sv
// Parallel-to-serial scl/sda transmitter: start, DATA_W bits MSB first, stop.
module ptosda_tx
    import ptosda_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    ptosda_if.slave    bus
);
    localparam int                BCNT_W   = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [BCNT_W-1:0]   r_bitcnt;
    logic                r_scl;
    logic                r_sda;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_load;
    logic                w_phase_end;
    logic                w_pre_end;
    logic [DATA_W-1:0]   w_shift_nxt;

    assign w_load      = (r_state == IDLE);
    assign w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};

    sda_phase_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .o_phase_end (w_phase_end),
        .o_pre_end   (w_pre_end)
    );

    // Frame FSM; every output is registered and set on the edge that enters its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_scl    <= 1'b1;
            r_sda    <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state  <= START;
                        r_shift  <= bus.in_data;
                        r_bitcnt <= '0;
                        r_scl    <= 1'b1;
                        r_sda    <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_phase_end) begin
                        r_state <= BIT_LO;
                        r_scl   <= 1'b0;
                        r_sda   <= r_shift[DATA_W-1];
                    end
                end
                BIT_LO: begin
                    if (w_phase_end) begin
                        r_state <= BIT_HI;
                        r_scl   <= 1'b1;
                    end
                end
                BIT_HI: begin
                    if (w_phase_end) begin
                        r_shift  <= w_shift_nxt;
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_scl    <= 1'b0;
                        if (r_bitcnt == LAST_BIT) begin
                            r_state <= STOP_LO;
                            r_sda   <= 1'b0;
                        end else begin
                            r_state <= BIT_LO;
                            r_sda   <= w_shift_nxt[DATA_W-1];
                        end
                    end
                end
                STOP_LO: begin
                    if (w_phase_end) begin
                        r_state <= STOP_SU;
                        r_scl   <= 1'b1;
                        r_sda   <= 1'b0;
                    end
                end
                STOP_SU: begin
                    if (w_phase_end) begin
                        r_state <= STOP;
                        r_scl   <= 1'b1;
                        r_sda   <= 1'b1;
                        // A one-cycle STOP phase is also its own last cycle.
                        r_done  <= (CLK_DIV == 1);
                    end
                end
                STOP: begin
                    if (w_phase_end) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_pre_end) begin
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_scl   <= 1'b1;
                    r_sda   <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.scl      = r_scl;
    assign bus.sda      = r_sda;

endmodule

// File: tb/tb_ptosda_tx.sv
// Directed bench for ptosda_tx at CLK_DIV = 1, 2 and 5.
module tb_ptosda_tx;
    import ptosda_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ptosda_if #(.DATA_W(4)) b1 ();
    ptosda_if #(.DATA_W(4)) b2 ();
    ptosda_if #(.DATA_W(4)) b5 ();

    ptosda_tx #(.DATA_W(4), .CLK_DIV(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    ptosda_tx #(.DATA_W(4), .CLK_DIV(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    ptosda_tx #(.DATA_W(4), .CLK_DIV(5)) u5 (.clk(clk), .rst(rst), .bus(b5));

    int   sel = 2;
    logic m_scl, m_sda, m_done, m_ready, m_busy;

    always_comb begin
        m_scl = b2.scl; m_sda = b2.sda; m_done = b2.done; m_ready = b2.in_ready; m_busy = b2.busy;
        case (sel)
            1: begin m_scl = b1.scl; m_sda = b1.sda; m_done = b1.done; m_ready = b1.in_ready; m_busy = b1.busy; end
            5: begin m_scl = b5.scl; m_sda = b5.sda; m_done = b5.done; m_ready = b5.in_ready; m_busy = b5.busy; end
            default: ;
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;

    int         cyc;
    logic       p_scl, p_sda;
    bit         in_frame;
    int         bits;
    logic [3:0] nib;
    logic [3:0] frames[$];
    int         bad, done_cnt;
    logic       wscl[0:127];
    logic       wsda[0:127];
    logic       wbusy[0:127];

    typedef struct {
        int         s;
        logic [3:0] data;
        int         exp_done;
        int         exp_ready;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d);
        case (sel)
            1:       begin b1.in_valid = v; b1.in_data = d; end
            5:       begin b5.in_valid = v; b5.in_data = d; end
            default: begin b2.in_valid = v; b2.in_data = d; end
        endcase
    endtask

    task automatic mon_clear();
        in_frame = 1'b0; bits = 0; nib = '0; frames.delete();
        bad = 0; done_cnt = 0; p_scl = 1'b1; p_sda = 1'b1; cyc = 0;
    endtask

    // One cycle: sample at negedge, decode start/stop and capture on scl rise.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (m_done === 1'b1) done_cnt++;
        if (p_scl === 1'b1 && m_scl === 1'b1 && m_sda !== p_sda) begin
            if (m_sda === 1'b0 && !in_frame) begin
                in_frame = 1'b1; bits = 0; nib = '0;
            end else if (m_sda === 1'b1 && in_frame && bits == 4) begin
                in_frame = 1'b0; frames.push_back(nib);
            end else begin
                bad++;
            end
        end
        if (p_scl === 1'b0 && m_scl === 1'b1 && in_frame && bits < 4) begin
            nib = {nib[2:0], m_sda};
            bits++;
        end
        if (cyc < 128) begin wscl[cyc] = m_scl; wsda[cyc] = m_sda; wbusy[cyc] = m_busy; end
        p_scl = m_scl; p_sda = m_sda;
    endtask

    task automatic run_frame(input int s, input logic [3:0] d, output int t_done, output int t_ready);
        sel = s;
        mon_clear();
        t_done = -1; t_ready = -1;
        drive(1'b1, d);
        while (t_ready < 0 && cyc < 400) begin
            step();
            if (cyc == 1) drive(1'b0, d);
            if (m_done === 1'b1 && t_done < 0) t_done = cyc;
            if (m_ready === 1'b1) t_ready = cyc;
        end
    endtask

    int td, tr, zeros;
    int r25, b26, s26;

    initial begin
        b1.in_valid = 0; b1.in_data = '0;
        b2.in_valid = 0; b2.in_data = '0;
        b5.in_valid = 0; b5.in_data = '0;
        rst = 1'b1;
        mon_clear();
        repeat (3) step();
        chk("reset scl", int'(m_scl), 1);
        chk("reset sda", int'(m_sda), 1);
        chk("reset in_ready", int'(m_ready), 1);
        chk("reset busy", int'(m_busy), 0);
        chk("reset done", int'(m_done), 0);
        chk("reset ready div1", int'(b1.in_ready), 1);
        chk("reset ready div5", int'(b5.in_ready), 1);

        // Reset and in_valid together: nothing accepted.
        drive(1'b1, 4'h5);
        step(); step();
        chk("rst+valid ready", int'(m_ready), 1);
        chk("rst+valid busy", int'(m_busy), 0);
        chk("rst+valid sda", int'(m_sda), 1);
        drive(1'b0, 4'h0);
        rst = 1'b0;
        step();

        // Frame 1010 at default divider: exact waveform.
        run_frame(2, 4'b1010, td, tr);
        chk("t1 busy c1", int'(wbusy[1]), 1);
        chk("t1 sda c1", int'(wsda[1]), 0);
        chk("t1 scl c1", int'(wscl[1]), 1);
        chk("t1 sda c2", int'(wsda[2]), 0);
        chk("t1 scl c3", int'(wscl[3]), 0);
        chk("t1 sda c3", int'(wsda[3]), 1);
        chk("t1 scl c5", int'(wscl[5]), 1);
        chk("t1 sda c7", int'(wsda[7]), 0);
        chk("t1 sda c11", int'(wsda[11]), 1);
        chk("t1 sda c22", int'(wsda[22]), 0);
        chk("t1 scl c23", int'(wscl[23]), 1);
        chk("t1 sda c23", int'(wsda[23]), 1);
        chk("t1 done cycle", td, 24);
        chk("t1 ready cycle", tr, 25);
        chk("t1 frame phases", tr - 1, FRAME_PHASES * 2);

        // Table: all 16 nibbles at CLK_DIV=2, plus CLK_DIV=1 and 5 frames.
        for (int i = 0; i < 16; i++) tbl[i] = '{2, 4'(i), 24, 25};
        tbl[16] = '{1, 4'b0110, 12, 13};
        tbl[17] = '{1, 4'b1001, 12, 13};
        tbl[18] = '{5, 4'b1111, 60, 61};
        tbl[19] = '{5, 4'b0011, 60, 61};
        for (int i = 0; i < 20; i++) begin
            run_frame(tbl[i].s, tbl[i].data, td, tr);
            chk($sformatf("vec%0d nibble", i), (frames.size() == 1) ? int'(frames[0]) : -1, int'(tbl[i].data));
            chk($sformatf("vec%0d done cycle", i), td, tbl[i].exp_done);
            chk($sformatf("vec%0d ready cycle", i), tr, tbl[i].exp_ready);
            chk($sformatf("vec%0d sda while scl high", i), bad, 0);
            chk($sformatf("vec%0d done count", i), done_cnt, 1);
        end

        // CLK_DIV=5 phase widths and sda held high through all bit phases.
        run_frame(5, 4'b1111, td, tr);
        chk("t6 scl c5", int'(wscl[5]), 1);
        chk("t6 scl c6", int'(wscl[6]), 0);
        chk("t6 scl c10", int'(wscl[10]), 0);
        chk("t6 scl c11", int'(wscl[11]), 1);
        zeros = 0;
        for (int c = 6; c <= 45; c++) if (wsda[c] !== 1'b1) zeros++;
        chk("t6 sda low in bits", zeros, 0);
        chk("t6 sda stop_lo c46", int'(wsda[46]), 0);

        // in_valid held high with changing data across a frame.
        sel = 2;
        mon_clear();
        drive(1'b1, 4'hC);
        r25 = -1; b26 = -1; s26 = -1;
        for (int k = 1; k <= 55; k++) begin
            step();
            if (cyc <= 25) drive(1'b1, (cyc >= 20) ? 4'h3 : 4'(cyc * 5));
            else drive(1'b0, 4'h0);
            if (cyc == 25) r25 = int'(m_ready);
            if (cyc == 26) begin b26 = int'(m_busy); s26 = int'(m_sda); end
        end
        chk("t3 ready first idle", r25, 1);
        chk("t3 busy restart", b26, 1);
        chk("t3 sda restart", s26, 0);
        chk("t3 frame count", frames.size(), 2);
        chk("t3 frame0", (frames.size() >= 1) ? int'(frames[0]) : -1, 12);
        chk("t3 frame1", (frames.size() >= 2) ? int'(frames[1]) : -1, 3);
        chk("t3 done count", done_cnt, 2);
        chk("t3 sda while scl high", bad, 0);

        // Reset during BIT_HI of bit 2.
        sel = 2;
        mon_clear();
        drive(1'b1, 4'b1011);
        while (cyc < 9) begin
            step();
            if (cyc == 1) drive(1'b0, 4'h0);
        end
        chk("t4 pre scl", int'(m_scl), 1);
        chk("t4 pre sda", int'(m_sda), 0);
        rst = 1'b1;
        step();
        chk("t4 scl", int'(m_scl), 1);
        chk("t4 sda", int'(m_sda), 1);
        chk("t4 in_ready", int'(m_ready), 1);
        chk("t4 busy", int'(m_busy), 0);
        chk("t4 done", int'(m_done), 0);
        rst = 1'b0;
        step();
        run_frame(2, 4'b0110, td, tr);
        chk("t4 after nibble", (frames.size() == 1) ? int'(frames[0]) : -1, 6);
        chk("t4 after done", td, 24);
        chk("t4 after ready", tr, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
